// File: rtl/mdu_pkg.sv
// Shared encodings and defaults for the multiply/divide unit.
// MDU_MADD_EN enables MDOP 7 (signed multiply-accumulate into HI/LO).
package mdu_pkg;

   localparam int unsigned MDOP_W          = 3;
   localparam int unsigned DATA_W          = 32;
   localparam int unsigned MULT_CYCLES_DEF = 5;
   localparam int unsigned DIV_CYCLES_DEF  = 10;

   typedef enum logic [MDOP_W-1:0] {
      MD_NONE  = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6,
      MD_MADD  = 3'd7
   } mdop_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   // True for opcodes that launch a multi-cycle operation.
   function automatic logic is_start(input logic [MDOP_W-1:0] op);
      logic r;
      r = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
`ifdef MDU_MADD_EN
      r = r || (op == MD_MADD);
`endif
      return r;
   endfunction

   // True for opcodes that use the multiply latency.
   function automatic logic is_mul(input logic [MDOP_W-1:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_MADD);
   endfunction

endpackage

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit holding the HI/LO registers.
// MDU_MADD_EN: when defined, MDOP 7 performs signed {HI,LO} += A*B.
module mdu
   import mdu_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [MDOP_W-1:0]   MDOP,
   input  logic [DATA_W-1:0]   A,
   input  logic [DATA_W-1:0]   B,
   output logic                busy,
   output logic                md_active,
   output logic [DATA_W-1:0]   HI,
   output logic [DATA_W-1:0]   LO
);

   localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
   localparam int unsigned PROD_W  = 2 * DATA_W;

   state_e              state, state_n;
   logic [CNT_W-1:0]    cnt, cnt_n;
   mdop_e               op_q, op_n;
   logic [DATA_W-1:0]   a_q, a_n, b_q, b_n;
   logic [DATA_W-1:0]   hi_q, hi_n, lo_q, lo_n;
   logic                busy_q, busy_n;
   logic                start_ok;

   logic [PROD_W-1:0]   prod_s, prod_u, acc;
   logic [DATA_W-1:0]   b_div, a_mag, b_mag, q_m, r_m;
   logic [DATA_W-1:0]   q_s, r_s, q_u, r_u;

   assign busy      = busy_q;
   assign HI        = hi_q;
   assign LO        = lo_q;
   assign md_active = busy_q | is_start(MDOP);

   // Result datapath on the latched operands; divisor forced nonzero to keep the divider X-free.
   always_comb begin
      prod_s = {{DATA_W{a_q[DATA_W-1]}}, a_q} * {{DATA_W{b_q[DATA_W-1]}}, b_q};
      prod_u = {{DATA_W{1'b0}}, a_q} * {{DATA_W{1'b0}}, b_q};
      acc    = {hi_q, lo_q} + prod_s;
      b_div  = (b_q == '0) ? DATA_W'(1) : b_q;
      a_mag  = a_q[DATA_W-1]   ? (~a_q + DATA_W'(1))   : a_q;
      b_mag  = b_div[DATA_W-1] ? (~b_div + DATA_W'(1)) : b_div;
      q_m    = a_mag / b_mag;
      r_m    = a_mag % b_mag;
      q_s    = (a_q[DATA_W-1] ^ b_div[DATA_W-1]) ? (~q_m + DATA_W'(1)) : q_m;
      r_s    = a_q[DATA_W-1] ? (~r_m + DATA_W'(1)) : r_m;
      q_u    = a_q / b_div;
      r_u    = a_q % b_div;
   end

   // Next-state, operand latch and HI/LO update decisions.
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      op_n     = op_q;
      a_n      = a_q;
      b_n      = b_q;
      hi_n     = hi_q;
      lo_n     = lo_q;
      start_ok = 1'b0;

      case (state)
         ST_IDLE: begin
            if (is_start(MDOP)) begin
               start_ok = 1'b1;
            end else if (MDOP == MD_MTHI) begin
               hi_n = A;
            end else if (MDOP == MD_MTLO) begin
               lo_n = A;
            end
         end
         ST_RUN: begin
            if (cnt == CNT_W'(1)) begin
               state_n = ST_IDLE;
               case (op_q)
                  MD_MULT:  {hi_n, lo_n} = prod_s;
                  MD_MULTU: {hi_n, lo_n} = prod_u;
                  MD_MADD:  {hi_n, lo_n} = acc;
                  MD_DIV:   if (b_q != '0) begin hi_n = r_s; lo_n = q_s; end
                  MD_DIVU:  if (b_q != '0) begin hi_n = r_u; lo_n = q_u; end
                  default:  ;
               endcase
               // A new start may overlap the commit edge.
               start_ok = is_start(MDOP);
            end else begin
               cnt_n = cnt - CNT_W'(1);
            end
         end
         default: state_n = ST_IDLE;
      endcase

      if (start_ok) begin
         state_n = ST_RUN;
         op_n    = mdop_e'(MDOP);
         a_n     = A;
         b_n     = B;
         cnt_n   = is_mul(MDOP) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
      end

      busy_n = (state_n == ST_RUN);
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         op_q   <= MD_NONE;
         a_q    <= '0;
         b_q    <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         busy_q <= 1'b0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         op_q   <= op_n;
         a_q    <= a_n;
         b_q    <= b_n;
         hi_q   <= hi_n;
         lo_q   <= lo_n;
         busy_q <= busy_n;
      end
   end

endmodule

// File: tb/tb_mdu.sv
// Directed testbench for mdu; honours MDU_MADD_EN to pick the MDOP 7 scenario.
`timescale 1ns/1ps
module tb_mdu;
   import mdu_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  MDOP;
   logic [31:0] A, B;
   logic        busy, md_active;
   logic [31:0] HI, LO;

   int n_checks = 0;
   int n_fail   = 0;

   mdu dut (
      .clk       (clk),
      .reset     (reset),
      .MDOP      (MDOP),
      .A         (A),
      .B         (B),
      .busy      (busy),
      .md_active (md_active),
      .HI        (HI),
      .LO        (LO)
   );

   always #5 clk = ~clk;

   // Advance one rising edge and settle just past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Count edges until busy drops, bounded.
   task automatic wait_idle(output int n);
      n = 0;
      while (busy === 1'b1 && n < 50) begin
         tick();
         n++;
      end
   endtask

   // Issue a start for one edge and return the observed busy length.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int n);
      MDOP = op; A = a; B = b;
      tick();
      MDOP = MD_NONE;
      wait_idle(n);
   endtask

   task automatic write_hilo(input logic [31:0] h, input logic [31:0] l);
      MDOP = MD_MTHI; A = h; tick();
      MDOP = MD_MTLO; A = l; tick();
      MDOP = MD_NONE;
   endtask

   task automatic test_reset();
      reset = 1'b1; MDOP = MD_NONE; A = '0; B = '0;
      tick(); tick();
      reset = 1'b0;
      n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_checks++; if (HI !== 32'h0)       begin n_fail++; $display("FAIL reset_hi: got %h expected 00000000", HI); end
      n_checks++; if (LO !== 32'h0)       begin n_fail++; $display("FAIL reset_lo: got %h expected 00000000", LO); end
      n_checks++; if (md_active !== 1'b0) begin n_fail++; $display("FAIL reset_md_active: got %b expected 0", md_active); end
   endtask

   task automatic test_mult();
      int n;
      MDOP = MD_MULT; #1;
      n_checks++; if (md_active !== 1'b1) begin n_fail++; $display("FAIL mult_md_active: got %b expected 1", md_active); end
      run_op(MD_MULT, 32'hFFFF_FFFF, 32'd2, n);
      n_checks++; if (n !== 5)               begin n_fail++; $display("FAIL mult_busy_len: got %0d expected 5", n); end
      n_checks++; if (HI !== 32'hFFFF_FFFF)  begin n_fail++; $display("FAIL mult_hi: got %h expected ffffffff", HI); end
      n_checks++; if (LO !== 32'hFFFF_FFFE)  begin n_fail++; $display("FAIL mult_lo: got %h expected fffffffe", LO); end
   endtask

   task automatic test_multu();
      int n;
      run_op(MD_MULTU, 32'hFFFF_FFFF, 32'd2, n);
      n_checks++; if (n !== 5)               begin n_fail++; $display("FAIL multu_busy_len: got %0d expected 5", n); end
      n_checks++; if (HI !== 32'h0000_0001)  begin n_fail++; $display("FAIL multu_hi: got %h expected 00000001", HI); end
      n_checks++; if (LO !== 32'hFFFF_FFFE)  begin n_fail++; $display("FAIL multu_lo: got %h expected fffffffe", LO); end
   endtask

   task automatic test_div();
      int n;
      run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, n);
      n_checks++; if (n !== 10)              begin n_fail++; $display("FAIL div_busy_len: got %0d expected 10", n); end
      n_checks++; if (LO !== 32'hFFFF_FFFD)  begin n_fail++; $display("FAIL div_lo: got %h expected fffffffd", LO); end
      n_checks++; if (HI !== 32'hFFFF_FFFF)  begin n_fail++; $display("FAIL div_hi: got %h expected ffffffff", HI); end
      run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, n);
      n_checks++; if (LO !== 32'h8000_0000)  begin n_fail++; $display("FAIL div_ovf_lo: got %h expected 80000000", LO); end
      n_checks++; if (HI !== 32'h0)          begin n_fail++; $display("FAIL div_ovf_hi: got %h expected 00000000", HI); end
      run_op(MD_DIVU, 32'd100, 32'd7, n);
      n_checks++; if (LO !== 32'd14)         begin n_fail++; $display("FAIL divu_lo: got %h expected 0000000e", LO); end
      n_checks++; if (HI !== 32'd2)          begin n_fail++; $display("FAIL divu_hi: got %h expected 00000002", HI); end
   endtask

   task automatic test_div_zero();
      int n;
      write_hilo(32'h11, 32'h22);
      n_checks++; if (HI !== 32'h11) begin n_fail++; $display("FAIL mthi_direct: got %h expected 00000011", HI); end
      run_op(MD_DIVU, 32'd7, 32'd0, n);
      n_checks++; if (n !== 10)      begin n_fail++; $display("FAIL div0_busy_len: got %0d expected 10", n); end
      n_checks++; if (HI !== 32'h11) begin n_fail++; $display("FAIL div0_hi: got %h expected 00000011", HI); end
      n_checks++; if (LO !== 32'h22) begin n_fail++; $display("FAIL div0_lo: got %h expected 00000022", LO); end
   endtask

   task automatic test_ignore_busy();
      int n;
      write_hilo(32'h77, 32'h88);
      MDOP = MD_MULT; A = 32'd3; B = 32'd4;
      tick();
      MDOP = MD_NONE;
      tick();
      MDOP = MD_MTHI; A = 32'hDEAD; B = 32'd9;
      tick();
      MDOP = MD_NONE; A = 32'd0; B = 32'd0;
      n_checks++; if (HI !== 32'h77) begin n_fail++; $display("FAIL busy_mthi_hi: got %h expected 00000077", HI); end
      wait_idle(n);
      n_checks++; if (HI !== 32'h0)  begin n_fail++; $display("FAIL busy_mult_hi: got %h expected 00000000", HI); end
      n_checks++; if (LO !== 32'd12) begin n_fail++; $display("FAIL busy_mult_lo: got %h expected 0000000c", LO); end
      MDOP = MD_MTHI; A = 32'hDEAD;
      tick();
      MDOP = MD_NONE;
      n_checks++; if (HI !== 32'hDEAD) begin n_fail++; $display("FAIL idle_mthi_hi: got %h expected 0000dead", HI); end
   endtask

   task automatic test_back_to_back();
      int n;
      MDOP = MD_MULTU; A = 32'd5; B = 32'd6;
      tick();
      MDOP = MD_NONE;
      for (int i = 0; i < 4; i++) tick();
      MDOP = MD_MULTU; A = 32'd7; B = 32'd8;
      tick();
      MDOP = MD_NONE;
      n_checks++; if (LO !== 32'd30)  begin n_fail++; $display("FAIL b2b_first_lo: got %h expected 0000001e", LO); end
      n_checks++; if (busy !== 1'b1)  begin n_fail++; $display("FAIL b2b_busy: got %b expected 1", busy); end
      wait_idle(n);
      n_checks++; if (n !== 5)        begin n_fail++; $display("FAIL b2b_busy_len: got %0d expected 5", n); end
      n_checks++; if (LO !== 32'd56)  begin n_fail++; $display("FAIL b2b_second_lo: got %h expected 00000038", LO); end
   endtask

   task automatic test_reset_mid();
      write_hilo(32'h33, 32'h44);
      MDOP = MD_DIVU; A = 32'd100; B = 32'd7;
      tick();
      MDOP = MD_NONE;
      for (int i = 0; i < 3; i++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
      n_checks++; if (HI !== 32'h0)  begin n_fail++; $display("FAIL rst_mid_hi: got %h expected 00000000", HI); end
      n_checks++; if (LO !== 32'h0)  begin n_fail++; $display("FAIL rst_mid_lo: got %h expected 00000000", LO); end
      for (int i = 0; i < 12; i++) tick();
      n_checks++; if (LO !== 32'h0)  begin n_fail++; $display("FAIL rst_mid_late_lo: got %h expected 00000000", LO); end
   endtask

   task automatic test_madd();
      int n;
`ifdef MDU_MADD_EN
      write_hilo(32'h0, 32'd5);
      run_op(MD_MADD, 32'd3, 32'd4, n);
      n_checks++; if (n !== 5)       begin n_fail++; $display("FAIL madd_busy_len: got %0d expected 5", n); end
      n_checks++; if (LO !== 32'd17) begin n_fail++; $display("FAIL madd_lo: got %h expected 00000011", LO); end
      n_checks++; if (HI !== 32'h0)  begin n_fail++; $display("FAIL madd_hi: got %h expected 00000000", HI); end
`else
      write_hilo(32'h55, 32'h66);
      MDOP = MD_MADD; A = 32'd3; B = 32'd4; #1;
      n_checks++; if (md_active !== 1'b0) begin n_fail++; $display("FAIL op7_md_active: got %b expected 0", md_active); end
      tick();
      MDOP = MD_NONE;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL op7_busy: got %b expected 0", busy); end
      wait_idle(n);
      for (int i = 0; i < 6; i++) tick();
      n_checks++; if (HI !== 32'h55) begin n_fail++; $display("FAIL op7_hi: got %h expected 00000055", HI); end
      n_checks++; if (LO !== 32'h66) begin n_fail++; $display("FAIL op7_lo: got %h expected 00000066", LO); end
`endif
   endtask

   initial begin
      reset = 1'b1; MDOP = MD_NONE; A = '0; B = '0;
      test_reset();
      test_mult();
      test_multu();
      test_div();
      test_div_zero();
      test_ignore_busy();
      test_back_to_back();
      test_reset_mid();
      test_madd();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
